// File: rtl/operand_fetch_pkg.sv
// ---------------------------------------------------------------------------
// cpu32_regs_pkg
// Shared constants and types for the CPU32 operand-fetch stage and its
// register-file scoreboard.
//   ADDRSIZE    register address width
//   REGSNUM     number of architectural registers tracked
//   DATAW       register data width
//   opf_state_t operand-fetch FSM states
//   wb_pick     selects the writeback data that wins for a given register
// ---------------------------------------------------------------------------
package cpu32_regs_pkg;

  localparam int ADDRSIZE = 5;
  localparam int REGSNUM  = 32;
  localparam int DATAW    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } opf_state_t;

  // The register file is last-write-wins, so when both writeback ports hit
  // the same register, port 1 carries the value that actually lands.
  function automatic logic [DATAW-1:0] wb_pick(
    input logic [1:0]          wb_valid,
    input logic [ADDRSIZE-1:0] wb_addr0,
    input logic [ADDRSIZE-1:0] wb_addr1,
    input logic [DATAW-1:0]    wb_data0,
    input logic [DATAW-1:0]    wb_data1,
    input logic [ADDRSIZE-1:0] addr
  );
    logic [DATAW-1:0] res;
    res = '0;
    if (wb_valid[1] && (wb_addr1 == addr)) begin
      res = wb_data1;
    end else if (wb_valid[0] && (wb_addr0 == addr)) begin
      res = wb_data0;
    end
    return res;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// ---------------------------------------------------------------------------
// operand_fetch_if
// Bundles every bus the operand-fetch stage talks to:
//   in_*   decoded instruction from decode (valid/ready handshake)
//   out_*  operands to execute (valid/ready handshake)
//   wb_*   two writeback ports from the back end
//   rf_*   read and write ports of the 2R/2W register file
// Modports:
//   slave   the operand_fetch block itself
//   master  the surroundings (decode, execute, writeback, register file)
// ---------------------------------------------------------------------------
interface operand_fetch_if #(
  parameter int ADDRSIZE = cpu32_regs_pkg::ADDRSIZE
);

  // decode side
  logic                in_valid;
  logic                in_ready;
  logic [ADDRSIZE-1:0] in_rs0;
  logic [ADDRSIZE-1:0] in_rs1;
  logic [ADDRSIZE-1:0] in_rd;
  logic [1:0]          in_use;
  logic                in_wr;

  // execute side
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_op0;
  logic [31:0]         out_op1;
  logic [ADDRSIZE-1:0] out_rd;
  logic                out_wr;

  // writeback ports
  logic [1:0]          wb_valid;
  logic [ADDRSIZE-1:0] wb_addr0;
  logic [ADDRSIZE-1:0] wb_addr1;
  logic [31:0]         wb_data0;
  logic [31:0]         wb_data1;

  // register file ports
  logic [ADDRSIZE-1:0] rf_ra0;
  logic [ADDRSIZE-1:0] rf_ra1;
  logic [1:0]          rf_read;
  logic [31:0]         rf_rd0;
  logic [31:0]         rf_rd1;
  logic [ADDRSIZE-1:0] rf_wa0;
  logic [ADDRSIZE-1:0] rf_wa1;
  logic [31:0]         rf_wd0;
  logic [31:0]         rf_wd1;
  logic [1:0]          rf_write;

  modport slave (
    input  in_valid, in_rs0, in_rs1, in_rd, in_use, in_wr,
    output in_ready,
    output out_valid, out_op0, out_op1, out_rd, out_wr,
    input  out_ready,
    input  wb_valid, wb_addr0, wb_addr1, wb_data0, wb_data1,
    output rf_ra0, rf_ra1, rf_read,
    input  rf_rd0, rf_rd1,
    output rf_wa0, rf_wa1, rf_wd0, rf_wd1, rf_write
  );

  modport master (
    output in_valid, in_rs0, in_rs1, in_rd, in_use, in_wr,
    input  in_ready,
    input  out_valid, out_op0, out_op1, out_rd, out_wr,
    output out_ready,
    output wb_valid, wb_addr0, wb_addr1, wb_data0, wb_data1,
    input  rf_ra0, rf_ra1, rf_read,
    output rf_rd0, rf_rd1,
    input  rf_wa0, rf_wa1, rf_wd0, rf_wd1, rf_write
  );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// ---------------------------------------------------------------------------
// opf_scoreboard
// One busy flag per register: set when an instruction that writes the
// register is issued, cleared when a writeback to it is seen.
// Ports:
//   clk, rst                       clock, async active-high reset (all idle)
//   clr_en_i, clr_addr0/1_i        two clear ports (writebacks)
//   set_en_i, set_addr_i           one set port (issue of a writing instr)
//   look_rs0/rs1/rd_i              three lookup addresses
//   busy_rs0/rs1/rd_o              registered busy bit for each lookup
//   clearing_rs0/rs1_o             lookup register is being cleared this cycle
// ---------------------------------------------------------------------------
module opf_scoreboard #(
  parameter int ADDRSIZE = cpu32_regs_pkg::ADDRSIZE,
  parameter int REGSNUM  = cpu32_regs_pkg::REGSNUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          clr_en_i,
  input  logic [ADDRSIZE-1:0] clr_addr0_i,
  input  logic [ADDRSIZE-1:0] clr_addr1_i,
  input  logic                set_en_i,
  input  logic [ADDRSIZE-1:0] set_addr_i,
  input  logic [ADDRSIZE-1:0] look_rs0_i,
  input  logic [ADDRSIZE-1:0] look_rs1_i,
  input  logic [ADDRSIZE-1:0] look_rd_i,
  output logic                busy_rs0_o,
  output logic                busy_rs1_o,
  output logic                busy_rd_o,
  output logic                clearing_rs0_o,
  output logic                clearing_rs1_o
);

  logic [REGSNUM-1:0] busy_q;
  logic [REGSNUM-1:0] busy_d;

  // Clears are applied first and the set last, so an issue and a writeback
  // to the same register in one cycle leave it busy: the new writer is
  // still outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < REGSNUM; r++) begin
      if (clr_en_i[0] && (clr_addr0_i == ADDRSIZE'(r))) busy_d[r] = 1'b0;
      if (clr_en_i[1] && (clr_addr1_i == ADDRSIZE'(r))) busy_d[r] = 1'b0;
      if (set_en_i && (set_addr_i == ADDRSIZE'(r)))     busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookups see only the registered flags; a clear happening this cycle is
  // reported separately so the caller can decide whether to bypass it.
  always_comb begin
    busy_rs0_o     = busy_q[look_rs0_i];
    busy_rs1_o     = busy_q[look_rs1_i];
    busy_rd_o      = busy_q[look_rd_i];
    clearing_rs0_o = (clr_en_i[0] && (clr_addr0_i == look_rs0_i)) ||
                     (clr_en_i[1] && (clr_addr1_i == look_rs0_i));
    clearing_rs1_o = (clr_en_i[0] && (clr_addr0_i == look_rs1_i)) ||
                     (clr_en_i[1] && (clr_addr1_i == look_rs1_i));
  end

endmodule

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
// Issue-side client of the 2R/2W register file. Accepts decoded
// instructions, stalls on RAW/WAW hazards using a busy scoreboard, reads the
// source operands from the file and presents them downstream two cycles
// after acceptance. Writeback ports are forwarded straight onto the file's
// write ports.
// Ports:
//   clk   clock, all state on rising edge
//   rst   asynchronous active-high reset
//   opf   operand_fetch_if.slave: decode, execute, writeback and rf buses
// Configuration:
//   OPFETCH_BYPASS_EN  when defined, a source whose busy bit is being cleared
//                      by a writeback in the accept cycle is taken from that
//                      writeback data instead of stalling for a cycle.
// ---------------------------------------------------------------------------
module operand_fetch
  import cpu32_regs_pkg::*;
#(
  parameter int ADDRSIZE = cpu32_regs_pkg::ADDRSIZE,
  parameter int REGSNUM  = cpu32_regs_pkg::REGSNUM
) (
  input  logic            clk,
  input  logic            rst,
  operand_fetch_if.slave  opf
);

`ifdef OPFETCH_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  opf_state_t state_q, state_d;

  logic [ADDRSIZE-1:0] rd_q;
  logic                wr_q;
  logic [1:0]          use_q;
  logic [31:0]         op0_q;
  logic [31:0]         op1_q;
  logic [1:0]          byp_sel_q;
  logic [31:0]         byp_data0_q;
  logic [31:0]         byp_data1_q;

  logic busy_rs0, busy_rs1, busy_rd;
  logic clr_rs0, clr_rs1;
  logic haz_src0, haz_src1, haz_rd, hazard;
  logic accept;
  logic in_ready_w;
  logic out_valid_w;
  logic [1:0] rf_read_w;

  opf_scoreboard #(
    .ADDRSIZE (ADDRSIZE),
    .REGSNUM  (REGSNUM)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .clr_en_i       (opf.wb_valid),
    .clr_addr0_i    (opf.wb_addr0),
    .clr_addr1_i    (opf.wb_addr1),
    .set_en_i       (accept & opf.in_wr),
    .set_addr_i     (opf.in_rd),
    .look_rs0_i     (opf.in_rs0),
    .look_rs1_i     (opf.in_rs1),
    .look_rd_i      (opf.in_rd),
    .busy_rs0_o     (busy_rs0),
    .busy_rs1_o     (busy_rs1),
    .busy_rd_o      (busy_rd),
    .clearing_rs0_o (clr_rs0),
    .clearing_rs1_o (clr_rs1)
  );

  // A busy source being written back this very cycle would read stale data
  // from the file, so it stalls unless bypass is built in. The destination
  // check never bypasses: a pending writer must retire before a new one.
  // Only registered busy bits are consulted, so an instruction whose source
  // equals its own destination does not stall on itself.
  always_comb begin
    haz_src0 = opf.in_use[0] & busy_rs0 & ~(BypassEn & clr_rs0);
    haz_src1 = opf.in_use[1] & busy_rs1 & ~(BypassEn & clr_rs1);
    haz_rd   = opf.in_wr & busy_rd;
    hazard   = haz_src0 | haz_src1 | haz_rd;
  end

  // FSM next-state and handshake outputs. The file read is issued only in
  // the accept cycle; its data comes back registered one cycle later.
  always_comb begin
    state_d     = state_q;
    in_ready_w  = 1'b0;
    accept      = 1'b0;
    out_valid_w = 1'b0;
    rf_read_w   = 2'b00;
    case (state_q)
      IDLE: begin
        in_ready_w = ~hazard;
        if (opf.in_valid && !hazard) begin
          accept    = 1'b1;
          rf_read_w = opf.in_use;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        state_d = HOLD;
      end
      HOLD: begin
        out_valid_w = 1'b1;
        if (opf.out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction fields and any bypass value are latched at accept; operands
  // are captured in WAIT when the file's read data is present. Unused
  // sources present zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q        <= '0;
      wr_q        <= 1'b0;
      use_q       <= 2'b00;
      op0_q       <= '0;
      op1_q       <= '0;
      byp_sel_q   <= 2'b00;
      byp_data0_q <= '0;
      byp_data1_q <= '0;
    end else begin
      if (accept) begin
        rd_q         <= opf.in_rd;
        wr_q         <= opf.in_wr;
        use_q        <= opf.in_use;
        byp_sel_q[0] <= opf.in_use[0] & busy_rs0 & clr_rs0;
        byp_sel_q[1] <= opf.in_use[1] & busy_rs1 & clr_rs1;
        byp_data0_q  <= wb_pick(opf.wb_valid, opf.wb_addr0, opf.wb_addr1,
                                opf.wb_data0, opf.wb_data1, opf.in_rs0);
        byp_data1_q  <= wb_pick(opf.wb_valid, opf.wb_addr0, opf.wb_addr1,
                                opf.wb_data0, opf.wb_data1, opf.in_rs1);
      end
      if (state_q == WAIT) begin
        if (!use_q[0])                      op0_q <= '0;
        else if (BypassEn && byp_sel_q[0]) op0_q <= byp_data0_q;
        else                               op0_q <= opf.rf_rd0;
        if (!use_q[1])                      op1_q <= '0;
        else if (BypassEn && byp_sel_q[1]) op1_q <= byp_data1_q;
        else                               op1_q <= opf.rf_rd1;
      end
    end
  end

  assign opf.in_ready  = in_ready_w;
  assign opf.out_valid = out_valid_w;
  assign opf.out_op0   = op0_q;
  assign opf.out_op1   = op1_q;
  assign opf.out_rd    = rd_q;
  assign opf.out_wr    = wr_q;

  assign opf.rf_ra0    = opf.in_rs0;
  assign opf.rf_ra1    = opf.in_rs1;
  assign opf.rf_read   = rf_read_w;

  // Writebacks go to the file unchanged; the scoreboard only watches them.
  assign opf.rf_write  = opf.wb_valid;
  assign opf.rf_wa0    = opf.wb_addr0;
  assign opf.rf_wa1    = opf.wb_addr1;
  assign opf.rf_wd0    = opf.wb_data0;
  assign opf.rf_wd1    = opf.wb_data1;

endmodule
